// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit LED PWM; colour sampled only at frame ends, optional +/-1 fade per frame.
// Latency: outputs one register stage after the cnt/duty compare; no backpressure, free-running while enabled.
module rgb_pwm_driver #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        fade,
   input  logic [23:0] light,
   output logic        red_pwm,
   output logic        green_pwm,
   output logic        blue_pwm,
   output logic        frame_done
);

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

   logic [15:0] pre_q, pre_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  duty_r_q, duty_r_d;
   logic [7:0]  duty_g_q, duty_g_d;
   logic [7:0]  duty_b_q, duty_b_d;
   logic        red_q, red_d;
   logic        green_q, green_d;
   logic        blue_q, blue_d;
   logic        frame_done_q, frame_done_d;
   logic        tick;
   logic        frame_end;

   // Saturating step toward the target; a plain jump when fading is off.
   function automatic logic [7:0] next_duty(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic       fade_en);
      logic [7:0] res;
      res = tgt;
      if (fade_en) begin
         if (cur < tgt) begin
            res = cur + 8'd1;
         end else if (cur > tgt) begin
            res = cur - 8'd1;
         end else begin
            res = cur;
         end
      end
      return res;
   endfunction

   always_comb begin
      tick      = enable && (pre_q == PRE_MAX);
      frame_end = tick && (cnt_q == 8'hFF);
   end

   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      if (!enable) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 8'd1;
      end else begin
         pre_d = pre_q + 16'd1;
      end
   end

   always_comb begin
      duty_r_d = duty_r_q;
      duty_g_d = duty_g_q;
      duty_b_d = duty_b_q;
      if (frame_end) begin
         duty_r_d = next_duty(duty_r_q, light[23:16], fade);
         duty_g_d = next_duty(duty_g_q, light[15:8],  fade);
         duty_b_d = next_duty(duty_b_q, light[7:0],   fade);
      end
   end

   // Compare uses the pre-update counter and duties, so a reload never cuts a frame short.
   always_comb begin
      red_d        = enable && (cnt_q < duty_r_q);
      green_d      = enable && (cnt_q < duty_g_q);
      blue_d       = enable && (cnt_q < duty_b_q);
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q        <= '0;
         cnt_q        <= '0;
         duty_r_q     <= '0;
         duty_g_q     <= '0;
         duty_b_q     <= '0;
         red_q        <= 1'b0;
         green_q      <= 1'b0;
         blue_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         cnt_q        <= cnt_d;
         duty_r_q     <= duty_r_d;
         duty_g_q     <= duty_g_d;
         duty_b_q     <= duty_b_d;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign red_pwm    = red_q;
   assign green_pwm  = green_q;
   assign blue_pwm   = blue_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Downstream stage of the lights selector: consumes the 24-bit `light` word and drives three physical LED channels with 8-bit pulse-width modulation. New colour values are sampled only at PWM frame boundaries, so outputs never glitch mid-frame. An optional fade mode ramps each channel's duty by one step per frame toward the requested value.

## Interface
- `PRESCALE`, default 4: clock cycles per PWM tick; legal range 1..65535.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = run PWM; 0 = counters held at 0, outputs low.
- `fade`  in  1  1 = duties step by ±1 per frame; 0 = duties jump to target.
- `light`  in  24  target colour: [23:16] red, [15:8] green, [7:0] blue.
- `red_pwm`  out  1  red channel PWM output, registered.
- `green_pwm`  out  1  green channel PWM output, registered.
- `blue_pwm`  out  1  blue channel PWM output, registered.
- `frame_done`  out  1  one-cycle pulse at the end of each 256-tick frame.

## Operation
- **Prescaler** `pre` (16 bit, counts 0..PRESCALE-1).
  - `tick` = enable && (pre == PRESCALE-1).
  - On `tick`, `pre` wraps to 0; otherwise it increments while enable = 1.
- **Frame counter** `cnt` (8 bit).
  - Increments on `tick`; wraps 255 → 0.
  - `frame_end` = tick && (cnt == 255).
- **Duty registers** `duty_r`, `duty_g`, `duty_b` (8 bit each).
  - Updated only on `frame_end`; `light` is sampled in that same cycle.
  - fade = 0: duty <= target byte.
  - fade = 1: duty > target → duty−1; duty < target → duty+1; equal → hold. No overshoot, no wrap; 0 and 255 are reachable and saturate.
- **Outputs**
  - x_pwm <= enable && (cnt < duty_x), evaluated with pre-update `cnt` and `duty` values.
  - Duty 0 → output constantly low; duty 255 → output high for 255 of 256 ticks.
  - frame_done <= frame_end.
- **enable = 0**
  - `pre` and `cnt` are forced to 0 synchronously.
  - All PWM outputs and `frame_done` go 0 next cycle.
  - Duty registers hold their values.
  - On re-enable, a frame starts from `cnt` = 0 with the held duties.
- **Changes to `light` between frame ends** are ignored; only the value present in the `frame_end` cycle matters.
- **Simultaneous `frame_end` and change of `fade`**: the `fade` value in that cycle selects the update rule.

## Timing
- **Reset (async assert)**: `pre` = 0, `cnt` = 0, all duties = 0, `red_pwm`/`green_pwm`/`blue_pwm` = 0, `frame_done` = 0. Release is synchronous to the next `clk` edge.
- **Frame length**: 256 × PRESCALE cycles while enable = 1.
- **Output latency**: x_pwm reflects the compare of the current `cnt`/`duty` one clock later (single register stage). `frame_done` is high the cycle after `frame_end`, for exactly 1 cycle.
- **First frame after reset**: all duties are 0, so outputs stay low until the first `frame_end` loads `light`. The new duties apply starting at `cnt` = 0 of the next frame.
- **Fade ramp**: going from duty a to target b takes |a−b| frames.
- **Reset mid-frame**: everything returns to reset values immediately; no partial frame is completed.

## Test plan
- **Jump load.** PRESCALE = 1, enable = 1, fade = 0, light = 24'h80_FF_00, run 2 frames → after the first `frame_done`:
  - `red_pwm` high for 128 of 256 cycles;
  - `green_pwm` high for 255 of 256 cycles;
  - `blue_pwm` always 0.
  - `frame_done` pulses every 256 cycles.
- **Prescale.** PRESCALE = 4, light = 24'h40_40_40, fade = 0 → frame = 1024 cycles, each output high for 256 consecutive cycles per frame; `frame_done` period 1024.
- **Fade.** PRESCALE = 1, duties preloaded to 0, fade = 1, light = 24'h03_00_02:
  - `duty_r` reads 1, 2, 3, 3 and `duty_b` reads 1, 2, 2, 2 after successive frame ends; `duty_g` stays 0.
  - Then set light = 24'h00_00_00: `duty_r` ramps down 3, 2, 1, 0 with no underflow.
- **Mid-frame change.** Change `light` from 24'hFFFFFF to 24'h000000 at `cnt` = 100 → the current frame keeps its old duties; the new value takes effect only after the next `frame_done`.
- **Enable drop.** Deassert `enable` at `cnt` = 50 → all outputs 0 next cycle, `cnt` = 0, duties unchanged. Reassert → the frame restarts at `cnt` = 0 with the same duties.
- **Async reset.** Assert `rst` between clock edges mid-frame with duty 200 → outputs and duties are 0 immediately, without waiting for a clock edge; after release, outputs stay low until the first `frame_end` reload.
